// File: rtl/hex_cmd_decoder_if.sv
// Byte-stream / ALU command bus between the UART receiver, the hex command decoder and the ALU.
// The decoder takes the slave modport; the UART/ALU side takes the master modport.
interface hex_cmd_decoder_if;
   logic [7:0] uart_in;
   logic       uin_valid;
   logic       alu_done;
   logic [7:0] operand_a;
   logic [7:0] operand_b;
   logic [1:0] opcode;
   logic       alu_start;
   logic       cmd_err;
   logic       busy;

   modport master (
      output uart_in, uin_valid, alu_done,
      input  operand_a, operand_b, opcode, alu_start, cmd_err, busy
   );

   modport slave (
      input  uart_in, uin_valid, alu_done,
      output operand_a, operand_b, opcode, alu_start, cmd_err, busy
   );
endinterface

// File: rtl/hex_cmd_decoder.sv
// Parses "HH op HH CR" ASCII frames into ALU operands/opcode with a one-cycle start pulse.
// Optional LOWERCASE_HEX_EN: also accept 'a'-'f' as hex digits.
module hex_cmd_decoder #(
   parameter int unsigned TIMEOUT = 1000000
) (
   input logic             clk,
   input logic             rst,
   hex_cmd_decoder_if.slave bus
);

   localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(64'(TIMEOUT) + 64'd1);
   localparam logic [7:0]  CR = 8'h0D;

   typedef enum logic [2:0] {A_HI, A_LO, OP, B_HI, B_LO, TERM, BUSY, ERR} state_t;

   function automatic logic is_hex(input logic [7:0] c);
      logic r;
      r = (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46);
`ifdef LOWERCASE_HEX_EN
      r = r || (c >= 8'h61 && c <= 8'h66);
`endif
      return r;
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] c);
      logic [3:0] v;
      v = 4'h0;
      if (c >= 8'h30 && c <= 8'h39) v = 4'(c - 8'h30);
      if (c >= 8'h41 && c <= 8'h46) v = 4'(c - 8'h37);
`ifdef LOWERCASE_HEX_EN
      if (c >= 8'h61 && c <= 8'h66) v = 4'(c - 8'h57);
`endif
      return v;
   endfunction

   function automatic logic is_op(input logic [7:0] c);
      return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h26) || (c == 8'h7C);
   endfunction

   function automatic logic [1:0] op_val(input logic [7:0] c);
      logic [1:0] v;
      case (c)
         8'h2D:   v = 2'b01;
         8'h26:   v = 2'b10;
         8'h7C:   v = 2'b11;
         default: v = 2'b00;
      endcase
      return v;
   endfunction

   state_t        state_q, state_d;
   logic [7:0]    a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic [1:0]    op_sh_q, op_sh_d;
   logic [7:0]    opa_q, opa_d, opb_q, opb_d;
   logic [1:0]    opc_q, opc_d;
   logic          start_q, start_d, err_q, err_d, busy_q, busy_d;
   logic [CW-1:0] tmo_q, tmo_d;

   logic          byte_hex, byte_cr, good, tmo_hit;
   logic [3:0]    nib;
   state_t        adv;

   // State, shadow and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= A_HI;
         a_sh_q  <= 8'h00;
         b_sh_q  <= 8'h00;
         op_sh_q <= 2'b00;
         opa_q   <= 8'h00;
         opb_q   <= 8'h00;
         opc_q   <= 2'b00;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         op_sh_q <= op_sh_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         opc_q   <= opc_d;
         start_q <= start_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state, shadow capture, command issue and inter-character timeout
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      op_sh_d  = op_sh_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      opc_d    = opc_q;
      start_d  = 1'b0;
      err_d    = 1'b0;
      good     = 1'b0;
      adv      = state_q;
      byte_hex = is_hex(bus.uart_in);
      byte_cr  = (bus.uart_in == CR);
      nib      = hex_val(bus.uart_in);
      tmo_hit  = (TIMEOUT != 0) && (tmo_q == CW'(TIMEOUT));

      case (state_q)
         A_HI: begin
            if (bus.uin_valid && byte_hex) begin
               a_sh_d[7:4] = nib;
               state_d     = A_LO;
            end else if (bus.uin_valid && !byte_cr) begin
               err_d   = 1'b1;
               state_d = ERR;
            end
         end
         BUSY: begin
            if (bus.alu_done) state_d = A_HI;
         end
         ERR: begin
            if (bus.uin_valid && byte_cr) state_d = A_HI;
         end
         default: begin
            if (bus.uin_valid) begin
               case (state_q)
                  A_LO: begin
                     good = byte_hex;
                     adv  = OP;
                     a_sh_d[3:0] = nib;
                  end
                  OP: begin
                     good    = is_op(bus.uart_in);
                     adv     = B_HI;
                     op_sh_d = op_val(bus.uart_in);
                  end
                  B_HI: begin
                     good = byte_hex;
                     adv  = B_LO;
                     b_sh_d[7:4] = nib;
                  end
                  B_LO: begin
                     good = byte_hex;
                     adv  = TERM;
                     b_sh_d[3:0] = nib;
                  end
                  TERM: begin
                     good = byte_cr;
                     adv  = BUSY;
                  end
                  default: begin
                     good = 1'b0;
                     adv  = A_HI;
                  end
               endcase
               if (good) begin
                  state_d = adv;
                  if (state_q == TERM) begin
                     opa_d   = a_sh_q;
                     opb_d   = b_sh_q;
                     opc_d   = op_sh_q;
                     start_d = 1'b1;
                  end
               end else begin
                  // CR resynchronises straight away; anything else waits for the next CR
                  err_d   = 1'b1;
                  state_d = byte_cr ? A_HI : ERR;
               end
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = A_HI;
            end
         end
      endcase

      busy_d = (state_d == BUSY);

      if (bus.uin_valid || state_q == A_HI || state_q == BUSY || state_q == ERR)
         tmo_d = '0;
      else if (tmo_q != {CW{1'b1}})
         tmo_d = tmo_q + CW'(1);
      else
         tmo_d = tmo_q;
   end

   assign bus.operand_a = opa_q;
   assign bus.operand_b = opb_q;
   assign bus.opcode    = opc_q;
   assign bus.alu_start = start_q;
   assign bus.cmd_err   = err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_hex_cmd_decoder.sv
// Self-checking bench for hex_cmd_decoder: directed frames plus randomized traffic
// compared every cycle against a frame-level reference model.
module tb_hex_cmd_decoder;

   localparam int unsigned TMO = 16;
   localparam logic [7:0]  CR  = 8'h0D;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hex_cmd_decoder_if bus ();

   hex_cmd_decoder #(.TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int n_start  = 0;
   int n_err    = 0;

   // Reference model: the current line as a character queue plus coarse flags
   logic [7:0] line[$];
   bit         m_busy, m_err;
   int         idle;
   logic [7:0] ea, eb;
   logic [1:0] eop;
   bit         estart, eerr;

   function automatic int hv(input logic [7:0] c);
      string up = "0123456789ABCDEF";
      string lo = "0123456789abcdef";
      for (int i = 0; i < 16; i++) begin
         if (8'(up[i]) == c) return i;
`ifdef LOWERCASE_HEX_EN
         if (8'(lo[i]) == c) return i;
`endif
      end
      if (lo.len() == 0) return -2;
      return -1;
   endfunction

   function automatic int opidx(input logic [7:0] c);
      string ops = "+-&|";
      for (int i = 0; i < 4; i++)
         if (8'(ops[i]) == c) return i;
      return -1;
   endfunction

   function automatic bit slot_ok(input int pos, input logic [7:0] c);
      if (pos == 2) return opidx(c) >= 0;
      if (pos == 5) return c == CR;
      return hv(c) >= 0;
   endfunction

   task automatic model_reset();
      line.delete();
      m_busy = 0; m_err = 0; idle = 0;
      ea = 8'h00; eb = 8'h00; eop = 2'b00;
      estart = 0; eerr = 0;
   endtask

   task automatic model_update(input bit v, input logic [7:0] c, input bit d);
      estart = 0;
      eerr   = 0;
      if (m_busy) begin
         if (d) m_busy = 0;
      end else if (m_err) begin
         if (v && c == CR) m_err = 0;
      end else if (v) begin
         idle = 0;
         if (slot_ok(line.size(), c)) begin
            line.push_back(c);
            if (line.size() == 6) begin
               ea     = 8'(hv(line[0]) * 16 + hv(line[1]));
               eop    = 2'(opidx(line[2]));
               eb     = 8'(hv(line[3]) * 16 + hv(line[4]));
               estart = 1;
               m_busy = 1;
               line.delete();
            end
         end else begin
            if (!(c == CR && line.size() == 0)) eerr = 1;
            if (c != CR) m_err = 1;
            line.delete();
         end
      end else if (line.size() > 0) begin
         if (idle == int'(TMO)) begin
            eerr = 1;
            line.delete();
            idle = 0;
         end else begin
            idle++;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input bit v, input logic [7:0] c, input bit d);
      @(negedge clk);
      bus.uin_valid = v;
      bus.uart_in   = v ? c : 8'($urandom);
      bus.alu_done  = d;
      model_update(v, c, d);
      @(posedge clk);
      #1;
      if (bus.alu_start === 1'b1) n_start++;
      if (bus.cmd_err === 1'b1) n_err++;
      chk("alu_start", 8'(bus.alu_start), 8'(estart));
      chk("cmd_err",   8'(bus.cmd_err),   8'(eerr));
      chk("busy",      8'(bus.busy),      8'(m_busy));
      chk("operand_a", bus.operand_a,     ea);
      chk("operand_b", bus.operand_b,     eb);
      chk("opcode",    8'(bus.opcode),    8'(eop));
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) step(1, 8'(s[i]), 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0);
   endtask

   function automatic logic [7:0] rand_hex();
      string dg = "0123456789ABCDEFabcdef";
      return 8'(dg[$urandom % 22]);
   endfunction

   function automatic logic [7:0] rand_junk();
      string j = "Gxz *\r9+";
      if ($urandom % 3 == 0) return 8'($urandom);
      return 8'(j[$urandom % 8]);
   endfunction

   initial begin
      int s0, e0;
      logic [7:0] fr[6];
      string ops = "+-&|";

      bus.uart_in   = 8'h00;
      bus.uin_valid = 1'b0;
      bus.alu_done  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst operand_a", bus.operand_a, 8'h00);
      chk("rst operand_b", bus.operand_b, 8'h00);
      chk("rst opcode", 8'(bus.opcode), 8'h00);
      chk("rst alu_start", 8'(bus.alu_start), 8'h00);
      chk("rst cmd_err", 8'(bus.cmd_err), 8'h00);
      chk("rst busy", 8'(bus.busy), 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Basic frame, then completion
      s0 = n_start;
      send_str("A5+3C"); step(1, CR, 0);
      chk("A5 start count", 8'(n_start - s0), 8'd1);
      chk("A5 operand_a", bus.operand_a, 8'hA5);
      chk("A5 operand_b", bus.operand_b, 8'h3C);
      chk("A5 opcode", 8'(bus.opcode), 8'h0);
      chk("A5 busy", 8'(bus.busy), 8'h1);
      idle_cycles(3);
      step(0, 8'h00, 1);
      chk("A5 busy after done", 8'(bus.busy), 8'h0);

      // Frame received while busy is dropped
      s0 = n_start;
      send_str("FF|00"); step(1, CR, 0);
      send_str("12&34"); step(1, CR, 0);
      step(1, 8'h35, 1);
      idle_cycles(2);
      chk("busy drop start count", 8'(n_start - s0), 8'd1);
      chk("busy drop operand_a", bus.operand_a, 8'hFF);
      chk("busy drop operand_b", bus.operand_b, 8'h00);
      chk("busy drop opcode", 8'(bus.opcode), 8'h3);

      // Malformed frame, resync, then good frame
      s0 = n_start; e0 = n_err;
      send_str("1G"); step(1, CR, 0);
      send_str("0F-01"); step(1, CR, 0);
      chk("bad G err count", 8'(n_err - e0), 8'd1);
      chk("bad G start count", 8'(n_start - s0), 8'd1);
      chk("0F operand_a", bus.operand_a, 8'h0F);
      chk("0F operand_b", bus.operand_b, 8'h01);
      chk("0F opcode", 8'(bus.opcode), 8'h1);
      step(0, 8'h00, 1);

      // Inter-character timeout; lone CR is silent
      s0 = n_start; e0 = n_err;
      send_str("7");
      idle_cycles(int'(TMO) + 4);
      chk("timeout err count", 8'(n_err - e0), 8'd1);
      chk("timeout operand_a kept", bus.operand_a, 8'h0F);
      e0 = n_err;
      step(1, CR, 0);
      idle_cycles(2);
      chk("empty line err count", 8'(n_err - e0), 8'd0);
      chk("empty line start count", 8'(n_start - s0), 8'd0);

      // Lowercase hex digits
      s0 = n_start; e0 = n_err;
      send_str("ab+cd"); step(1, CR, 0);
`ifdef LOWERCASE_HEX_EN
      chk("lower start count", 8'(n_start - s0), 8'd1);
      chk("lower operand_a", bus.operand_a, 8'hAB);
      chk("lower operand_b", bus.operand_b, 8'hCD);
      step(0, 8'h00, 1);
`else
      chk("lower err count", 8'(n_err - e0), 8'd1);
      chk("lower start count", 8'(n_start - s0), 8'd0);
`endif

      // Reset mid-frame
      send_str("12+3");
      @(negedge clk);
      bus.uin_valid = 1'b0;
      bus.alu_done  = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst operand_a", bus.operand_a, 8'h00);
      chk("midrst operand_b", bus.operand_b, 8'h00);
      chk("midrst opcode", 8'(bus.opcode), 8'h00);
      chk("midrst busy", 8'(bus.busy), 8'h00);
      chk("midrst alu_start", 8'(bus.alu_start), 8'h00);
      chk("midrst cmd_err", 8'(bus.cmd_err), 8'h00);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      s0 = n_start;
      send_str("00-00"); step(1, CR, 0);
      chk("post-rst start count", 8'(n_start - s0), 8'd1);
      chk("post-rst opcode", 8'(bus.opcode), 8'h1);
      step(0, 8'h00, 1);

      // Randomized frames with occasional corruption, long gaps and traffic while busy
      for (int f = 0; f < 180; f++) begin
         fr[0] = rand_hex();
         fr[1] = rand_hex();
         fr[2] = 8'(ops[$urandom % 4]);
         fr[3] = rand_hex();
         fr[4] = rand_hex();
         fr[5] = CR;
         if ($urandom % 5 == 0) fr[$urandom % 6] = rand_junk();
         for (int i = 0; i < 6; i++) begin
            int gap;
            gap = ($urandom % 12 == 0) ? int'(TMO) + 2 : int'($urandom % 3);
            for (int g = 0; g < gap; g++) step(0, 8'h00, ($urandom % 20) == 0);
            step(1, fr[i], ($urandom % 20) == 0);
         end
         for (int k = 0; k < int'($urandom % 6); k++)
            step($urandom % 2 == 1, ($urandom % 2 == 1) ? CR : rand_hex(), 0);
         step(($urandom % 4) == 0, rand_hex(), 1);
      end

      idle_cycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/hex_cmd_decoder.md
# hex_cmd_decoder

Upstream command parser for the UART calculator path. It consumes ASCII bytes from the UART receiver, parses frames of the form `HH op HH CR`, and presents two 8-bit operands plus a 2-bit opcode to the ALU with a one-cycle start pulse. It then holds off new frames until the ALU reports completion, because the ALU result feeds the hex-to-ASCII response encoder.

## Interface
- `TIMEOUT`, default 1000000: inter-character timeout in clk cycles, counted while a frame is partially received; 0 disables the timeout.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `uart_in`  input  8  received byte; valid only when `uin_valid`=1.
- `uin_valid`  input  1  one-cycle pulse per received byte.
- `alu_done`  input  1  one-cycle pulse when the ALU finishes the issued command.
- `operand_a`  output  8  first operand; reset 8'h00.
- `operand_b`  output  8  second operand; reset 8'h00.
- `opcode`  output  2  operation code; reset 2'b00.
- `alu_start`  output  1  one-cycle start pulse to the ALU; reset 0.
- `cmd_err`  output  1  one-cycle pulse on a malformed or timed-out frame; reset 0.
- `busy`  output  1  high from `alu_start` until `alu_done`; reset 0.

## Operation
- Hex digits accepted: '0'-'9' (0x30-0x39) map to 0-9; 'A'-'F' (0x41-0x46) map to 10-15.
- Operator characters: '+' (0x2B) = 00, '-' (0x2D) = 01, '&' (0x26) = 10, '|' (0x7C) = 11.
- Terminator: CR (0x0D).
- FSM states: A_HI, A_LO, OP, B_HI, B_LO, TERM, BUSY, ERR. Reset state is A_HI. The FSM advances only on cycles with `uin_valid`=1, except in BUSY and on timeout.
- A_HI → A_LO on a hex digit (upper nibble into a shadow register), then A_LO → OP on a hex digit.
- OP → B_HI on an operator character, then B_HI → B_LO → TERM on hex digits.
- TERM → BUSY on CR. On this transition, copy the shadow registers to `operand_a`, `operand_b` and `opcode`, and assert `alu_start`.
- BUSY → A_HI on `alu_done`. Every byte received in BUSY is dropped silently.
- An unexpected byte in A_HI..TERM:
  - If the byte is CR, pulse `cmd_err` and go to A_HI (resync).
  - Otherwise, pulse `cmd_err` and go to ERR.
- ERR drops bytes until CR arrives, then goes to A_HI. No second `cmd_err` is raised.
- CR arriving in A_HI (empty line) is ignored. It does not raise an error.
- Outputs `operand_a`, `operand_b` and `opcode` change only on the TERM→BUSY transition. They stay stable until the next command issues.
- Timeout counter:
  - Clears on every `uin_valid` and whenever the FSM is in A_HI, BUSY or ERR.
  - Otherwise increments, saturating.
  - When it reaches `TIMEOUT` (with `TIMEOUT`≠0), pulse `cmd_err`, discard the partial frame and go to A_HI.
- Timeout counter width is $clog2(TIMEOUT+1), with a minimum of 1 bit.

## Timing
- All outputs are registered.
- `alu_start` is high exactly one cycle: the cycle after the edge that samples `uin_valid`=1 with CR in TERM.
- `busy` rises together with `alu_start`. It falls on the cycle after the edge that samples `alu_done`.
- `cmd_err` rises on the cycle after the edge that samples the offending byte or the timeout, and is high for one cycle.
- If `alu_done` and `uin_valid` are both high in BUSY, go to A_HI and drop the byte.
- If `alu_done` arrives outside BUSY, ignore it.
- Back-to-back bytes (`uin_valid` high on consecutive cycles) are each consumed. There is no backpressure.
- `rst` asserted mid-frame or in BUSY clears all state and outputs immediately. No `alu_start` or `cmd_err` is produced.

## Configuration
- `LOWERCASE_HEX_EN`:
  - Defined: 'a'-'f' (0x61-0x66) are also accepted as hex digits 10-15.
  - Undefined: lowercase letters are unexpected bytes and take the error path.

## Test plan
- Send "A5+3C\r" → one `alu_start` pulse, with `operand_a`=8'hA5, `operand_b`=8'h3C, `opcode`=00 and `busy`=1. Then pulse `alu_done` → `busy`=0, FSM back in A_HI.
- Send "FF|00\r", then send "12&34\r" while busy, then pulse `alu_done` → exactly one start with A=8'hFF, B=8'h00, op=11. The second frame's bytes are dropped, and the outputs still read FF/00/11.
- Send "1G", then "\r", then "0F-01\r" → one `cmd_err` pulse on 'G'. Then one start with A=8'h0F, B=8'h01, op=01.
- With `TIMEOUT`=16, send "7" and then go idle for 16 cycles → one `cmd_err` pulse, FSM back in A_HI, outputs unchanged. "\r" alone → no pulses at all.
- Send "ab+cd\r" → with `LOWERCASE_HEX_EN` defined: A=8'hAB, B=8'hCD, op=00. Without it: one `cmd_err` pulse and no `alu_start`.
- Assert `rst` in the middle of "12+3" → all outputs read 0 and the FSM is in A_HI. A following "00-00\r" issues a normal start.
